// File: rtl/pll_reconfig_seq.sv
// pll_reconfig_seq: rewrites the fractional PLL's N/M/K and C0..C2 counters from one of
// two compile-time clock profiles over the Avalon-MM management port, then waits for
// the PLL to re-lock.
// Ports:
//   refclk, rst          - 50 MHz management clock, synchronous active-high reset
//   cfg_start, cfg_sel   - one-cycle start request, profile select (latched on start)
//   pll_locked           - asynchronous PLL lock indication
//   mgmt_*               - Avalon-MM master to the reconfig block (write-only)
//   busy, done, error    - sequence in progress, success pulse, sticky lock timeout
`timescale 1ns/1ps
module pll_reconfig_seq #(
  parameter logic [17:0] P0_N  = 18'h10000,
  parameter logic [17:0] P0_M  = 18'h00404,
  parameter logic [31:0] P0_K  = 32'h0,
  parameter logic [17:0] P0_C0 = 18'h00202,
  parameter logic [17:0] P0_C1 = 18'h00202,
  parameter logic [17:0] P0_C2 = 18'h00202,
  parameter logic [17:0] P1_N  = 18'h10000,
  parameter logic [17:0] P1_M  = 18'h00404,
  parameter logic [31:0] P1_K  = 32'h0,
  parameter logic [17:0] P1_C0 = 18'h00202,
  parameter logic [17:0] P1_C1 = 18'h00202,
  parameter logic [17:0] P1_C2 = 18'h00202,
  parameter int unsigned LOCK_STABLE  = 16,
  parameter int unsigned LOCK_TIMEOUT = 1000000
) (
  input  logic        refclk,
  input  logic        rst,
  input  logic        cfg_start,
  input  logic        cfg_sel,
  input  logic        pll_locked,
  output logic [5:0]  mgmt_address,
  output logic        mgmt_write,
  output logic [31:0] mgmt_writedata,
  output logic        mgmt_read,
  input  logic        mgmt_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int unsigned IDX_W = 3;
  localparam int unsigned TO_W  = 24;
  localparam int unsigned ST_W  = $clog2(LOCK_STABLE + 1);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_WRITE     = 2'd1;
  localparam logic [1:0] S_WAIT_LOCK = 2'd2;
  localparam logic [1:0] S_DONE      = 2'd3;

  logic [1:0]       state, state_d;
  logic [IDX_W-1:0] idx, idx_d, idx_inc;
  logic             sel, sel_d;
  logic [ST_W-1:0]  stable_cnt, stable_cnt_d;
  logic [TO_W-1:0]  timeout_cnt, timeout_cnt_d;
  logic             lk_meta, lk_s;
  logic [5:0]       addr_d;
  logic             write_d;
  logic [31:0]      data_d;
  logic             busy_d, done_d, error_d;

  // Command list: register address for each step.
  function automatic logic [5:0] cmd_addr(input logic [IDX_W-1:0] i);
    logic [5:0] a;
    a = 6'd0;
    case (i)
      3'd0:    a = 6'd0;
      3'd1:    a = 6'd3;
      3'd2:    a = 6'd4;
      3'd3:    a = 6'd7;
      3'd4,
      3'd5,
      3'd6:    a = 6'd5;
      default: a = 6'd2;
    endcase
    return a;
  endfunction

  // Command list: write data for each step; C writes carry the counter select in [22:18].
  function automatic logic [31:0] cmd_data(input logic [IDX_W-1:0] i, input logic s);
    logic [31:0] d;
    d = 32'd0;
    case (i)
      3'd0:    d = 32'd0;
      3'd1:    d = {14'd0, (s ? P1_N : P0_N)};
      3'd2:    d = {14'd0, (s ? P1_M : P0_M)};
      3'd3:    d = s ? P1_K : P0_K;
      3'd4:    d = {9'd0, 5'd0, (s ? P1_C0 : P0_C0)};
      3'd5:    d = {9'd0, 5'd1, (s ? P1_C1 : P0_C1)};
      3'd6:    d = {9'd0, 5'd2, (s ? P1_C2 : P0_C2)};
      default: d = 32'd1;
    endcase
    return d;
  endfunction

  assign mgmt_read = 1'b0;

  // State, counters, lock synchroniser and registered outputs.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state          <= S_IDLE;
      idx            <= '0;
      sel            <= 1'b0;
      stable_cnt     <= '0;
      timeout_cnt    <= '0;
      lk_meta        <= 1'b0;
      lk_s           <= 1'b0;
      mgmt_address   <= 6'd0;
      mgmt_write     <= 1'b0;
      mgmt_writedata <= 32'd0;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
    end else begin
      state          <= state_d;
      idx            <= idx_d;
      sel            <= sel_d;
      stable_cnt     <= stable_cnt_d;
      timeout_cnt    <= timeout_cnt_d;
      lk_meta        <= pll_locked;
      lk_s           <= lk_meta;
      mgmt_address   <= addr_d;
      mgmt_write     <= write_d;
      mgmt_writedata <= data_d;
      busy           <= busy_d;
      done           <= done_d;
      error          <= error_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d       = state;
    idx_d         = idx;
    idx_inc       = idx + IDX_W'(1);
    sel_d         = sel;
    stable_cnt_d  = stable_cnt;
    timeout_cnt_d = timeout_cnt;
    addr_d        = mgmt_address;
    write_d       = mgmt_write;
    data_d        = mgmt_writedata;
    busy_d        = busy;
    done_d        = 1'b0;
    error_d       = error;

    case (state)
      S_IDLE: begin
        if (cfg_start) begin
          state_d = S_WRITE;
          sel_d   = cfg_sel;
          idx_d   = '0;
          error_d = 1'b0;
          busy_d  = 1'b1;
          write_d = 1'b1;
          addr_d  = cmd_addr('0);
          data_d  = cmd_data('0, cfg_sel);
        end
      end
      S_WRITE: begin
        // Transfer completes when the slave does not stall; next command follows immediately.
        if (!mgmt_waitrequest) begin
          if (idx == IDX_W'(7)) begin
            state_d       = S_WAIT_LOCK;
            write_d       = 1'b0;
            addr_d        = 6'd0;
            data_d        = 32'd0;
            stable_cnt_d  = '0;
            timeout_cnt_d = '0;
          end else begin
            idx_d  = idx_inc;
            addr_d = cmd_addr(idx_inc);
            data_d = cmd_data(idx_inc, sel);
          end
        end
      end
      S_WAIT_LOCK: begin
        timeout_cnt_d = timeout_cnt + TO_W'(1);
        stable_cnt_d  = lk_s ? stable_cnt + ST_W'(1) : '0;
        // Stable lock takes priority over a coincident timeout.
        if (stable_cnt_d == ST_W'(LOCK_STABLE)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else if (timeout_cnt_d == TO_W'(LOCK_TIMEOUT)) begin
          state_d = S_IDLE;
          error_d = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
